servo_pwm_capture: RTL
======================

Name: servo_pwm_capture

Overview:
- Receive-side counterpart of the servo PWM generator. Measures high time and period of an incoming servo-style PWM line in i_Clk cycles.
- Measures per pulse, flags out-of-range widths, and detects a dead line.
- Used for loopback checks of the generator output and for reading external RC receiver channels.
- Results come out as one registered word pair plus a one-cycle valid strobe.

Parameters:
- c_WIDTH, 24, width of all counters and measured outputs.
- c_MIN_PULSE, 50000, minimum legal high time in cycles (0.5 ms @ 100 MHz).
- c_MAX_PULSE, 250000, maximum legal high time in cycles (2.5 ms @ 100 MHz).
- c_TIMEOUT, 4000000, cycles with no edge before the line is declared dead (40 ms @ 100 MHz).

Ports:
- i_Clk  input  1  system clock, 100 MHz nominal.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Pwm  input  1  asynchronous PWM line.
- o_Pulse_Width  output  c_WIDTH  last measured high time, in cycles.
- o_Period  output  c_WIDTH  last measured rising-to-rising period, in cycles.
- o_Valid  output  1  one-cycle strobe when o_Pulse_Width/o_Period update.
- o_Range_Err  output  1  last captured width is <c_MIN_PULSE or >c_MAX_PULSE.
- o_Timeout  output  1  sticky; line dead; cleared by the next o_Valid.

Behaviour:
- Reset: one clock (i_Clk); asynchronous, active-low reset (i_Rst_n). While i_Rst_n=0:
  - all outputs = 0; state = IDLE; counters = 0; synchronizer flops = 0.
- Input path:
  - i_Pwm passes through a 2-flop synchronizer, then one more register for edge detect.
  - rise = sync & ~sync_d; fall = ~sync & sync_d.
  - Latency from an i_Pwm edge to the detected edge: 3 cycles. All measurements are taken on the synchronized signal.
- State machine (3 states):
  - IDLE: wait for rise. No measurement. On rise: high_cnt=1, per_cnt=1 -> HIGH.
  - HIGH: high_cnt and per_cnt increment each cycle.
    - On fall: freeze high_cnt -> LOW.
    - Since sync=0 at fall, high_cnt equals the number of cycles sync was 1.
  - LOW: per_cnt increments each cycle. On rise, in that same cycle:
    - o_Pulse_Width <= high_cnt; o_Period <= per_cnt.
    - o_Range_Err <= (high_cnt < c_MIN_PULSE) | (high_cnt > c_MAX_PULSE).
    - o_Valid <= 1 for one cycle; o_Timeout <= 0.
    - Restart with high_cnt=1, per_cnt=1 -> HIGH.
    - This gives back-to-back measurements with no lost pulses.
- Measurement semantics:
  - The first pulse after reset or timeout yields no o_Valid. Its period is only known at the next rise, so the first o_Valid comes at the second rise.
  - o_Valid asserts the cycle after the detected rise (registered output).
- Saturation: high_cnt and per_cnt saturate at 2^c_WIDTH-1 and never wrap.
- Timeout:
  - idle_cnt clears on any rise or fall and increments otherwise.
  - When idle_cnt reaches c_TIMEOUT-1 in HIGH or LOW:
    - o_Timeout <= 1 (sticky); state -> IDLE.
    - o_Pulse_Width, o_Period and o_Range_Err hold their last values.
  - In IDLE, idle_cnt also runs. o_Timeout can assert with a constant line from reset onward (stuck-high or stuck-low).
- Simultaneous events: a timeout reached on the same cycle as an edge loses; the edge is processed normally.
- Reset mid-operation: immediate return to reset values. The partial measurement is discarded and no o_Valid is produced.
- Width rules:
  - Comparisons are unsigned at c_WIDTH.
  - Parameters must satisfy c_MIN_PULSE <= c_MAX_PULSE < c_TIMEOUT < 2^c_WIDTH.

Test Plan:
- Nominal pulse stream:
  - Stimulus: i_Pwm with 100149-cycle high (753*133) and 2,000,000-cycle period, three pulses.
  - Required: exactly 2 o_Valid strobes, each with o_Pulse_Width=100149, o_Period=2000000, o_Range_Err=0, o_Timeout=0.
- Range limits:
  - Stimulus: widths 49999, 50000, 250000, 250001 at a 2,000,000-cycle period.
  - Required: o_Range_Err = 1, 0, 0, 1 respectively. Widths are reported exactly.
- Dead line:
  - Stimulus: after 2 valid pulses, hold i_Pwm=0.
  - Required: o_Timeout=1 exactly 4,000,000 cycles after the last detected fall. Outputs hold their last values.
  - Then resume pulses. Required: no o_Valid on the first rise; o_Valid with o_Timeout->0 on the second rise.
- Stuck high:
  - Stimulus: rise, then i_Pwm held 1 for 5,000,000 cycles.
  - Required: o_Timeout=1 and no o_Valid; a later fall/rise sequence recovers as in the dead-line case.
- Reset mid-pulse:
  - Stimulus: deassert i_Rst_n 60000 cycles into a high phase.
  - Required: all outputs 0 within the reset cycle (asynchronous). After release, the first o_Valid comes at the second full rise with correct values.
- Glitch and minimum timing:
  - Stimulus: pulse 1 cycle high, then an 8-cycle period.
  - Required: o_Pulse_Width=1, o_Period=8, o_Range_Err=1. Confirms edge latency and no off-by-one.

Source files
------------

// File: rtl/servo_pwm_capture.sv
`timescale 1ns / 1ps
// ----------------------------------------------------------------------------
// servo_pwm_capture
//
// Measures an incoming servo-style PWM line in i_Clk cycles. Each pulse's
// high time and its rising-to-rising period are captured. The pair is
// published on the rise that closes the period. That rise also starts the
// next measurement, so back-to-back pulses are never lost. Widths outside
// [c_MIN_PULSE, c_MAX_PULSE] are flagged. A line with no edge for c_TIMEOUT
// cycles is declared dead.
//
// Ports
//   i_Clk          system clock
//   i_Rst_n        asynchronous active-low reset
//   i_Pwm          asynchronous PWM input
//   o_Pulse_Width  last measured high time (cycles)
//   o_Period       last measured rising-to-rising period (cycles)
//   o_Valid        one-cycle strobe when o_Pulse_Width / o_Period update
//   o_Range_Err    last captured width is outside [c_MIN_PULSE, c_MAX_PULSE]
//   o_Timeout      sticky dead-line flag, cleared by the next o_Valid
//
// Parameters must satisfy c_MIN_PULSE <= c_MAX_PULSE < c_TIMEOUT < 2**c_WIDTH.
// ----------------------------------------------------------------------------
module servo_pwm_capture #(
    parameter int unsigned c_WIDTH     = 24,
    parameter int unsigned c_MIN_PULSE = 50000,
    parameter int unsigned c_MAX_PULSE = 250000,
    parameter int unsigned c_TIMEOUT   = 4000000
) (
    input  logic               i_Clk,
    input  logic               i_Rst_n,
    input  logic               i_Pwm,
    output logic [c_WIDTH-1:0] o_Pulse_Width,
    output logic [c_WIDTH-1:0] o_Period,
    output logic               o_Valid,
    output logic               o_Range_Err,
    output logic               o_Timeout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } state_t;

    localparam logic [c_WIDTH-1:0] c_ONE       = c_WIDTH'(1);
    localparam logic [c_WIDTH-1:0] c_MIN_W     = c_WIDTH'(c_MIN_PULSE);
    localparam logic [c_WIDTH-1:0] c_MAX_W     = c_WIDTH'(c_MAX_PULSE);
    localparam logic [c_WIDTH-1:0] c_IDLE_LAST = c_WIDTH'(c_TIMEOUT - 1);

    // Counters stop at all-ones instead of wrapping, so a long pulse never
    // comes back as a small, plausible-looking number.
    function automatic logic [c_WIDTH-1:0] sat_inc(input logic [c_WIDTH-1:0] v);
        return (&v) ? v : v + c_ONE;
    endfunction

    logic meta;
    logic sync;
    logic sync_d;
    logic rise;
    logic fall;
    logic idle_expired;

    state_t             state;
    logic [c_WIDTH-1:0] high_cnt;
    logic [c_WIDTH-1:0] per_cnt;
    logic [c_WIDTH-1:0] idle_cnt;

    // Two-flop synchronizer followed by one delay stage for edge detection.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its neighbour. A blocking assignment
    // here would collapse the chain into a single flop.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            meta   <= i_Pwm;
            sync   <= meta;
            sync_d <= sync;
        end
    end

    assign rise = sync & ~sync_d;
    assign fall = ~sync & sync_d;

    // An edge in the same cycle as the timeout wins, so expiry is masked by it.
    assign idle_expired = (idle_cnt == c_IDLE_LAST) && !(rise || fall);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state         <= ST_IDLE;
            high_cnt      <= '0;
            per_cnt       <= '0;
            idle_cnt      <= '0;
            o_Pulse_Width <= '0;
            o_Period      <= '0;
            o_Valid       <= 1'b0;
            o_Range_Err   <= 1'b0;
            o_Timeout     <= 1'b0;
        end else begin
            // NOTE: the strobe defaults low at the top of the clocked block.
            // Any branch below that does not assert it therefore yields a
            // single-cycle pulse, and the block needs no else-branch on
            // every path.
            o_Valid <= 1'b0;

            // The edge-free cycle counter holds at its terminal value, so
            // the dead-line condition stays true while the line is stuck.
            if (rise || fall) begin
                idle_cnt <= '0;
            end else if (idle_cnt != c_IDLE_LAST) begin
                idle_cnt <= idle_cnt + c_ONE;
            end

            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        high_cnt <= c_ONE;
                        per_cnt  <= c_ONE;
                        state    <= ST_HIGH;
                    end else if (idle_expired) begin
                        o_Timeout <= 1'b1;
                    end
                end

                ST_HIGH: begin
                    if (fall) begin
                        // sync is already 0 here, so high_cnt is frozen at
                        // the number of cycles the line was high.
                        per_cnt <= sat_inc(per_cnt);
                        state   <= ST_LOW;
                    end else if (idle_expired) begin
                        o_Timeout <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        high_cnt <= sat_inc(high_cnt);
                        per_cnt  <= sat_inc(per_cnt);
                    end
                end

                ST_LOW: begin
                    if (rise) begin
                        // The closing rise publishes the finished measurement
                        // and opens the next one in the same cycle.
                        o_Pulse_Width <= high_cnt;
                        o_Period      <= per_cnt;
                        o_Range_Err   <= (high_cnt < c_MIN_W) || (high_cnt > c_MAX_W);
                        o_Valid       <= 1'b1;
                        o_Timeout     <= 1'b0;
                        high_cnt      <= c_ONE;
                        per_cnt       <= c_ONE;
                        state         <= ST_HIGH;
                    end else if (idle_expired) begin
                        o_Timeout <= 1'b1;
                        state     <= ST_IDLE;
                    end else begin
                        per_cnt <= sat_inc(per_cnt);
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
